// File: rtl/float_pkg.sv
// Shared types and helpers for the parametrised float datapath: FSM states,
// field extract/pack for any EXP_W/MAN_W up to FP_MAX_W bits, and the RNE decision.
package float_pkg;

    localparam int FP_MAX_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        NORM,
        ROUND,
        OUT
    } state_e;

    function automatic logic fp_sign(input logic [FP_MAX_W-1:0] x, input int exp_w, input int man_w);
        return |((x >> (exp_w + man_w)) & FP_MAX_W'(1));
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_exp(input logic [FP_MAX_W-1:0] x, input int exp_w,
                                                   input int man_w);
        return (x >> man_w) & ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1));
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_man(input logic [FP_MAX_W-1:0] x, input int man_w);
        return x & ((FP_MAX_W'(1) << man_w) - FP_MAX_W'(1));
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_pack(input logic sign, input logic [FP_MAX_W-1:0] e,
                                                    input logic [FP_MAX_W-1:0] m,
                                                    input int exp_w, input int man_w);
        return (FP_MAX_W'(sign) << (exp_w + man_w)) | (e << man_w) | m;
    endfunction

    // Round-to-nearest-even: ties go to the even mantissa.
    function automatic logic rne_up(input logic guard, input logic sticky, input logic lsb);
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/float_round_pack.sv
// Combinational round/pack: RNE on a normalised mantissa, then flush-to-zero,
// saturation and packing into a {sign, exp, man} word.
module float_round_pack
    import float_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    localparam int W  = 1 + EXP_W + MAN_W,
    localparam int EW = EXP_W + 2
) (
    input  logic                 sign_i,
    input  logic signed [EW-1:0] exp_i,
    input  logic [MAN_W-1:0]     man_i,
    input  logic                 guard_i,
    input  logic                 sticky_i,
    output logic [W-1:0]         y_o
);

    localparam logic signed [EW-1:0] EXP_SAT = EW'((1 << EXP_W) - 1);

    logic [MAN_W:0]        man_sum;
    logic [MAN_W-1:0]      man_r;
    logic signed [EW-1:0]  exp_r;

    always_comb begin
        man_sum = {1'b0, man_i} + {{MAN_W{1'b0}}, rne_up(guard_i, sticky_i, man_i[0])};
        // A carry out of the mantissa means 1.11..1 rounded up to 10.0: bump the exponent.
        man_r   = man_sum[MAN_W] ? '0 : man_sum[MAN_W-1:0];
        exp_r   = exp_i + EW'(man_sum[MAN_W]);
        if (exp_r[EW-1] || exp_r == '0) begin
            y_o = {sign_i, {(W-1){1'b0}}};
        end else if (exp_r >= EXP_SAT) begin
            y_o = {sign_i, {(W-1){1'b1}}};
        end else begin
            y_o = W'(fp_pack(sign_i, FP_MAX_W'(exp_r[EXP_W-1:0]), FP_MAX_W'(man_r), EXP_W, MAN_W));
        end
    end

endmodule

// File: rtl/float_multiplier_param.sv
// Multicycle float multiplier for any EXP_W/MAN_W format with valid/ready on both
// sides: IDLE -> MUL -> NORM -> ROUND -> OUT, result held until consumed.
module float_multiplier_param
    import float_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
    parameter int BIAS  = (1 << (EXP_W - 1)) - 1,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y
);

    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;

    state_e               state_q;
    logic [W-1:0]         a_q, b_q, y_q;
    logic                 sign_q;
    logic signed [EW-1:0] e_q;
    logic [PW-1:0]        p_q;
    logic [MAN_W-1:0]     man_q;
    logic                 guard_q, sticky_q;
    logic                 in_ready_q, out_valid_q;

    logic [EXP_W-1:0]     exp_a, exp_b;
    logic [MAN_W-1:0]     man_a, man_b;
    logic                 zero_op, sign_d;
    logic [PW-1:0]        p_d;
    logic signed [EW-1:0] e_mul_d, e_norm_d;
    logic [PW-2:0]        p_norm;
    logic [MAN_W-1:0]     man_d;
    logic                 guard_d, sticky_d;
    logic [W-1:0]         y_d;

    assign exp_a   = EXP_W'(fp_exp(FP_MAX_W'(a_q), EXP_W, MAN_W));
    assign exp_b   = EXP_W'(fp_exp(FP_MAX_W'(b_q), EXP_W, MAN_W));
    assign man_a   = MAN_W'(fp_man(FP_MAX_W'(a_q), MAN_W));
    assign man_b   = MAN_W'(fp_man(FP_MAX_W'(b_q), MAN_W));
    assign sign_d  = fp_sign(FP_MAX_W'(a_q), EXP_W, MAN_W) ^ fp_sign(FP_MAX_W'(b_q), EXP_W, MAN_W);
    assign zero_op = (exp_a == '0) || (exp_b == '0);

    // A zero operand forces P=0 and E=0, which the round stage flushes to signed zero.
    assign p_d     = zero_op ? '0 : PW'({1'b1, man_a}) * PW'({1'b1, man_b});
    assign e_mul_d = zero_op ? '0
                   : $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - EW'(BIAS);

    assign p_norm   = p_q[PW-1] ? p_q[PW-2:0] : {p_q[PW-3:0], 1'b0};
    assign e_norm_d = e_q + EW'(p_q[PW-1]);
    assign man_d    = p_norm[PW-2 -: MAN_W];
    assign guard_d  = p_norm[PW-2-MAN_W];
    assign sticky_d = |p_norm[PW-3-MAN_W:0];

    float_round_pack #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round_pack (
        .sign_i  (sign_q),
        .exp_i   (e_q),
        .man_i   (man_q),
        .guard_i (guard_q),
        .sticky_i(sticky_q),
        .y_o     (y_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            y_q         <= '0;
            sign_q      <= 1'b0;
            e_q         <= '0;
            p_q         <= '0;
            man_q       <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        in_ready_q <= 1'b0;
                        state_q    <= MUL;
                    end
                end
                MUL: begin
                    sign_q  <= sign_d;
                    p_q     <= p_d;
                    e_q     <= e_mul_d;
                    state_q <= NORM;
                end
                NORM: begin
                    e_q      <= e_norm_d;
                    man_q    <= man_d;
                    guard_q  <= guard_d;
                    sticky_q <= sticky_d;
                    state_q  <= ROUND;
                end
                ROUND: begin
                    y_q         <= y_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule

// File: tb/tb_float_multiplier_param.sv
// Scoreboard bench: stimulus pushes hand-computed results, per-DUT monitors pop
// and compare result and latency when each DUT hands out a product.
module tb_float_multiplier_param;

    typedef struct {
        logic [15:0] exp_y;
        int          issue;
        string       name;
    } txn_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0]  a = '0, b = '0;
    logic        in_ready, out_valid;
    logic [7:0]  y;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic        in_ready16, out_valid16;
    logic [15:0] y16;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    txn_t q8[$];
    txn_t q16[$];

    float_multiplier_param #(.EXP_W(4), .MAN_W(3)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    float_multiplier_param #(.EXP_W(8), .MAN_W(7)) u_dut16 (
        .clock(clock), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .y(y16)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    endtask

    // Monitor for the e4m3 instance.
    int rise8 = 0;
    bit seen8 = 0;
    always @(negedge clock) begin
        txn_t t;
        if (out_valid === 1'b1 && !seen8) begin
            rise8 = cyc;
            seen8 = 1;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            seen8 = 0;
            if (q8.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out8: got out_valid=1 y=0x%0h, required no output", y);
            end else begin
                t = q8.pop_front();
                check({t.name, " y"}, 32'(y), 32'(t.exp_y));
                check({t.name, " latency"}, 32'(rise8 - t.issue), 32'd4);
                $display("txn %s y=0x%02h expected=0x%02h latency=%0d", t.name, y, t.exp_y[7:0],
                         rise8 - t.issue);
            end
        end
    end

    // Monitor for the bf16 instance.
    int rise16 = 0;
    bit seen16 = 0;
    always @(negedge clock) begin
        txn_t t;
        if (out_valid16 === 1'b1 && !seen16) begin
            rise16 = cyc;
            seen16 = 1;
        end
        if (out_valid16 === 1'b1 && out_ready16 === 1'b1) begin
            seen16 = 0;
            if (q16.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out16: got out_valid=1 y=0x%0h, required no output", y16);
            end else begin
                t = q16.pop_front();
                check({t.name, " y"}, 32'(y16), 32'(t.exp_y));
                check({t.name, " latency"}, 32'(rise16 - t.issue), 32'd4);
                $display("txn %s y=0x%04h expected=0x%04h latency=%0d", t.name, y16, t.exp_y,
                         rise16 - t.issue);
            end
        end
    end

    task automatic send(input bit sel, input logic [15:0] va, input logic [15:0] vb,
                        input logic [15:0] ey, input string nm, input bit push);
        int   t = 0;
        txn_t tx;
        while (((sel ? in_ready16 : in_ready) !== 1'b1) && t < 50) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            $display("FAIL %s in_ready_timeout: got in_ready=0, required 1", nm);
        end
        tx.exp_y = ey;
        tx.issue = cyc;
        tx.name  = nm;
        if (sel) begin
            a16 = va; b16 = vb; in_valid16 = 1'b1;
            if (push) q16.push_back(tx);
        end else begin
            a = va[7:0]; b = vb[7:0]; in_valid = 1'b1;
            if (push) q8.push_back(tx);
        end
        @(posedge clock);
        #1;
        in_valid   = 1'b0;
        in_valid16 = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((q8.size() != 0 || q16.size() != 0) && t < 100) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            $display("FAIL %s drain_timeout: got %0d pending, required 0", nm, q8.size() + q16.size());
        end
    endtask

    logic [7:0] va_tbl [17] = '{8'h38, 8'h3C, 8'h39, 8'h3C, 8'h77, 8'h08, 8'h88, 8'h00, 8'h80,
                                8'h03, 8'h39, 8'h78, 8'h08, 8'h08, 8'hB8, 8'h70, 8'hF7};
    logic [7:0] vb_tbl [17] = '{8'h38, 8'h3C, 8'h39, 8'h39, 8'h40, 8'h08, 8'h08, 8'h3C, 8'h3C,
                                8'h38, 8'h3E, 8'h30, 8'h38, 8'h30, 8'h3C, 8'h40, 8'h40};
    logic [7:0] vy_tbl [17] = '{8'h38, 8'h41, 8'h3A, 8'h3E, 8'h7F, 8'h00, 8'h80, 8'h00, 8'h80,
                                8'h00, 8'h40, 8'h70, 8'h08, 8'h00, 8'hBC, 8'h7F, 8'hFF};

    initial begin
        int t;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset y", 32'(y), 32'd0);
        check("reset y16", 32'(y16), 32'd0);
        reset = 1'b0;

        send(1'b1, 16'h3FC0, 16'h4000, 16'h4040, "bf16_1p5x2p0", 1'b1);
        send(1'b1, 16'h3FC0, 16'h3FC0, 16'h4010, "bf16_1p5x1p5", 1'b1);
        drain("bf16");

        for (int i = 0; i < 17; i++) begin
            send(1'b0, {8'h00, va_tbl[i]}, {8'h00, vb_tbl[i]}, {8'h00, vy_tbl[i]},
                 $sformatf("vec%0d_%02hx_x_%02hx", i, va_tbl[i], vb_tbl[i]), 1'b1);
        end
        drain("vectors");

        // Back-pressure: result must stay put while out_ready is low.
        out_ready = 1'b0;
        send(1'b0, 16'h003C, 16'h003C, 16'h0041, "backpressure", 1'b1);
        t = 0;
        while (out_valid !== 1'b1 && t < 20) begin
            @(posedge clock);
            #1;
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp hold%0d y", i), 32'(y), 32'h41);
            check($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        check("bp release out_valid", 32'(out_valid), 32'd0);

        // Reset while the operation sits in NORM discards it.
        send(1'b0, 16'h003C, 16'h0039, 16'h0000, "reset_in_norm", 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset y", 32'(y), 32'd0);
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("midreset no_stale out_valid", 32'(out_valid), 32'd0);

        send(1'b0, 16'h0038, 16'h0038, 16'h0038, "after_reset_1x1", 1'b1);
        drain("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/float_multiplier_param.md
Name: float_multiplier_param

Overview:
- Parametrised, handshaked successor to the fixed-format e4m3/bf16 multipliers: one multiplier for any EXP_W/MAN_W float format.
- Multicycle FSM datapath: accept → multiply → normalise → round/pack → hold result until consumed.
- Adds round-to-nearest-even, overflow saturation, underflow flush-to-zero, signed zeros and valid/ready flow control on both sides.
- Sits between activation/weight operand buffers and the accumulator in the MAC path.

Parameters:
- EXP_W, 4, exponent field width (4 → e4m3, 8 → bf16).
- MAN_W, 3, stored mantissa width; hidden bit implied.
- BIAS, (1<<(EXP_W-1))-1, exponent bias.
- W, 1+EXP_W+MAN_W, total operand/result width (derived; not overridden).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair a/b present.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A {sign, exp, man}.
- b  in  W  operand B.
- out_valid  out  1  y holds a finished result.
- out_ready  in  1  consumer takes y.
- y  out  W  product.

Behaviour:
- Reset (sampled on clock edge): state=IDLE, in_ready=1, out_valid=0, y=0, all datapath registers 0. Reset asserted mid-operation discards the operation; no stale out_valid afterwards.
- States and transitions:
  - IDLE: in_ready=1; on in_valid, register a/b → MUL.
  - MUL: form P = {1,manA}*{1,manB} (2*MAN_W+2 bits); E = expA+expB-BIAS in EXP_W+2-bit signed; sign = sA^sB → NORM.
  - NORM: if P MSB=1, E+=1 and take the mantissa from below the MSB, else from the bit below. Guard = next bit; sticky = OR of all lower bits → ROUND.
  - ROUND: RNE, round up iff guard & (sticky | mantissa LSB). Mantissa carry-out → mantissa=0, E+=1. Then apply exception rules and pack → OUT.
  - OUT: out_valid=1, y stable; leave to IDLE on out_ready. Latency from accept edge to out_valid is exactly 4 cycles. No operand is accepted while busy (in_ready=0 outside IDLE).
- Exception rules:
  - Zero/subnormal: any operand with exp field=0 is treated as zero; the result is signed zero {sA^sB, 0...} and bypasses to OUT on the same 4-cycle latency.
  - Underflow: final E ≤ 0 → signed zero (no subnormal output).
  - Overflow: final E ≥ 2^EXP_W-1, or E = 2^EXP_W-1 with any mantissa → saturate to {sign, all-ones exp, all-ones man}. No inf/NaN encoding; all-ones exponent is an ordinary finite value on input.
- Back-pressure: out_ready low holds y and out_valid indefinitely. out_ready high while not out_valid is ignored.
- Width rules: all intermediate exponent arithmetic is signed EXP_W+2 bits, so no wrap. The product register is exactly 2*MAN_W+2 bits.

Decomposition:
- float_pkg:
  - state enum {IDLE, MUL, NORM, ROUND, OUT}.
  - Helper functions for field extract/pack given EXP_W/MAN_W.
  - RNE decision function.
- Sub-module float_round_pack (combinational): takes sign, signed E, normalised mantissa, guard and sticky; returns the packed W-bit result with saturation/flush applied. It is reused by the planned adder.

Test Plan (EXP_W=4, MAN_W=3, out_ready=1 unless stated):
- Exact: a=0x38 (1.0), b=0x38 → y=0x38 four cycles after accept. a=0x3C, b=0x3C (1.5²) → y=0x41 (2.25).
- Rounding: a=0x39, b=0x39 (1.265625, guard 0) → y=0x3A. Tie a=0x3C, b=0x39 (1.6875, odd LSB) → rounds up to y=0x3E.
- Saturation/underflow: a=0x77, b=0x40 → y=0x7F. a=0x08, b=0x08 → y=0x00. a=0x88, b=0x08 → y=0x80.
- Zeros: a=0x00, b=0x3C → y=0x00. a=0x80, b=0x3C → y=0x80. a=0x03 (subnormal), b=0x38 → y=0x00.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles → y and out_valid stable, in_ready=0; release → IDLE next cycle.
  - Assert reset in NORM → next cycle out_valid=0, in_ready=1, y=0.
- Format sweep: EXP_W=8, MAN_W=7, a=0x3FC0 (1.5), b=0x4000 (2.0) → y=0x4040 (3.0).
